// File: rtl/iic_xfer_sequencer.sv
// IIC register-transfer sequencer: turns one command into a
// START/WRITE/READ/STOP event stream for the IIC master core.
module iic_xfer_sequencer #(
   parameter logic [7:0]  EV_START    = 8'h01,
   parameter logic [7:0]  EV_STOP     = 8'h02,
   parameter logic [7:0]  EV_WRITE    = 8'h03,
   parameter logic [7:0]  EV_RD_ACK   = 8'h04,
   parameter logic [7:0]  EV_RD_NACK  = 8'h05,
   parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
   input  logic       S_HCLK,
   input  logic       S_nREST,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_dev,
   input  logic [7:0] cmd_reg,
   input  logic [3:0] cmd_len,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       done,
   output logic       err_nack,
   output logic       err_timeout,
   output logic       iic_en,
   output logic       iic_rst,
   output logic [7:0] iic_sel,
   output logic [7:0] iic_send_data,
   output logic       iic_event_start,
   input  logic       iic_busy,
   input  logic       iic_qvld,
   input  logic       iic_ack,
   input  logic [7:0] iic_rec_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_NEXT,
      S_ABORT, S_RSTC, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      P_START, P_DEVW, P_REG, P_RSTART,
      P_DEVR, P_WDATA, P_RDATA, P_STOP
   } step_t;

   state_t      r_state;
   step_t       r_step;
   logic        r_rw;
   logic [6:0]  r_dev;
   logic [7:0]  r_reg;
   logic [3:0]  r_cnt;
   logic [15:0] r_to;
   logic [1:0]  r_rc;
   logic        r_qvld_d;

   logic [7:0]  w_sel;
   logic [7:0]  w_data;
   logic        w_go;
   logic        w_is_wr;
   logic        w_edge;
   logic        w_last;

   // event code and payload for the current step
   always_comb begin
      w_sel   = EV_STOP;
      w_data  = 8'h00;
      w_is_wr = 1'b0;
      w_last  = (r_cnt <= 4'd1);
      unique case (r_step)
         P_START, P_RSTART: w_sel = EV_START;
         P_DEVW: begin
            w_sel   = EV_WRITE;
            w_data  = {r_dev, 1'b0};
            w_is_wr = 1'b1;
         end
         P_REG: begin
            w_sel   = EV_WRITE;
            w_data  = r_reg;
            w_is_wr = 1'b1;
         end
         P_DEVR: begin
            w_sel   = EV_WRITE;
            w_data  = {r_dev, 1'b1};
            w_is_wr = 1'b1;
         end
         P_WDATA: begin
            w_sel   = EV_WRITE;
            w_data  = wr_data;
            w_is_wr = 1'b1;
         end
         P_RDATA: w_sel = w_last ? EV_RD_NACK : EV_RD_ACK;
         P_STOP:  w_sel = EV_STOP;
      endcase
      w_go   = !iic_busy && ((r_step != P_WDATA) || wr_valid);
      w_edge = iic_qvld && !r_qvld_d;
   end

   // sequencer FSM with registered outputs
   always_ff @(posedge S_HCLK) begin
      if (!S_nREST) begin
         r_state         <= S_IDLE;
         r_step          <= P_START;
         r_rw            <= 1'b0;
         r_dev           <= 7'h00;
         r_reg           <= 8'h00;
         r_cnt           <= 4'h0;
         r_to            <= 16'h0000;
         r_rc            <= 2'd0;
         r_qvld_d        <= 1'b0;
         cmd_ready       <= 1'b1;
         wr_ready        <= 1'b0;
         rd_data         <= 8'h00;
         rd_valid        <= 1'b0;
         done            <= 1'b0;
         err_nack        <= 1'b0;
         err_timeout     <= 1'b0;
         iic_en          <= 1'b1;
         iic_rst         <= 1'b0;
         iic_sel         <= 8'h00;
         iic_send_data   <= 8'h00;
         iic_event_start <= 1'b0;
      end else begin
         iic_event_start <= 1'b0;
         wr_ready        <= 1'b0;
         rd_valid        <= 1'b0;
         done            <= 1'b0;
         r_qvld_d        <= iic_qvld;
         unique case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_rw        <= cmd_rw;
                  r_dev       <= cmd_dev;
                  r_reg       <= cmd_reg;
                  r_cnt       <= (cmd_len == 4'd0) ? 4'd1 : cmd_len;
                  r_step      <= P_START;
                  err_nack    <= 1'b0;
                  err_timeout <= 1'b0;
                  cmd_ready   <= 1'b0;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_go) begin
                  iic_sel         <= w_sel;
                  iic_send_data   <= w_data;
                  iic_event_start <= 1'b1;
                  wr_ready        <= (r_step == P_WDATA);
                  r_qvld_d        <= 1'b0;
                  r_to            <= 16'h0000;
                  r_state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_edge) begin
                  r_state <= S_NEXT;
               end else if (r_to == TIMEOUT_CYC - 16'd1) begin
                  err_timeout <= 1'b1;
                  iic_rst     <= 1'b1;
                  r_rc        <= 2'd0;
                  r_state     <= S_RSTC;
               end else begin
                  r_to <= r_to + 16'd1;
               end
            end
            S_NEXT: begin
               if (w_is_wr && !iic_ack) begin
                  err_nack <= 1'b1;
                  r_state  <= S_ABORT;
               end else begin
                  r_state <= S_ISSUE;
                  unique case (r_step)
                     P_START:  r_step <= P_DEVW;
                     P_DEVW:   r_step <= P_REG;
                     P_REG:    r_step <= r_rw ? P_RSTART : P_WDATA;
                     P_RSTART: r_step <= P_DEVR;
                     P_DEVR:   r_step <= P_RDATA;
                     P_WDATA: begin
                        r_cnt <= (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
                        if (w_last) r_step <= P_STOP;
                     end
                     P_RDATA: begin
                        rd_data  <= iic_rec_data;
                        rd_valid <= 1'b1;
                        r_cnt <= (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
                        if (w_last) r_step <= P_STOP;
                     end
                     P_STOP: begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                     end
                  endcase
               end
            end
            S_ABORT: begin
               r_step  <= P_STOP;
               r_state <= S_ISSUE;
            end
            S_RSTC: begin
               if (r_rc == 2'd3) begin
                  iic_rst <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_rc <= r_rc + 2'd1;
               end
            end
            S_DONE: begin
               cmd_ready <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iic_xfer_sequencer.sv
// Directed bench for iic_xfer_sequencer with a small
// behavioural model of the IIC core event interface.
module tb_iic_xfer_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_rw = 1'b0;
   logic [6:0] cmd_dev = 7'h00;
   logic [7:0] cmd_reg = 8'h00;
   logic [3:0] cmd_len = 4'h0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       done;
   logic       err_nack;
   logic       err_timeout;
   logic       iic_en;
   logic       iic_rst;
   logic [7:0] iic_sel;
   logic [7:0] iic_send_data;
   logic       iic_event_start;
   logic       iic_busy = 1'b0;
   logic       iic_qvld = 1'b0;
   logic       iic_ack = 1'b1;
   logic [7:0] iic_rec_data = 8'h00;

   int checks = 0;
   int errors = 0;

   // model controls (written by the stimulus process)
   logic [7:0] wr_q[$];
   logic [7:0] rd_q[$];
   logic       wr_en = 1'b1;
   int         nack_idx = -1;
   logic       hang_rd = 1'b0;
   int         clr_tok = 0;

   // model state and logs (written by the model process)
   logic [7:0] log_sel[$];
   logic [7:0] log_tx[$];
   logic [7:0] rd_log[$];
   int         n_wr = 0;
   int         n_rd = 0;
   int         n_wrr = 0;
   int         n_done = 0;
   int         wr_idx = 0;
   int         m_dly = -1;
   int         m_tok = 0;

   iic_xfer_sequencer #(.TIMEOUT_CYC(16'd100)) dut (
      .S_HCLK          (clk),
      .S_nREST         (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_rw          (cmd_rw),
      .cmd_dev         (cmd_dev),
      .cmd_reg         (cmd_reg),
      .cmd_len         (cmd_len),
      .wr_data         (wr_data),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .done            (done),
      .err_nack        (err_nack),
      .err_timeout     (err_timeout),
      .iic_en          (iic_en),
      .iic_rst         (iic_rst),
      .iic_sel         (iic_sel),
      .iic_send_data   (iic_send_data),
      .iic_event_start (iic_event_start),
      .iic_busy        (iic_busy),
      .iic_qvld        (iic_qvld),
      .iic_ack         (iic_ack),
      .iic_rec_data    (iic_rec_data)
   );

   always #5 clk = ~clk;

   // core model: completes each event with a qvld pulse
   initial begin
      forever begin
         @(negedge clk);
         iic_qvld = 1'b0;
         if (clr_tok != m_tok) begin
            m_tok = clr_tok;
            log_sel.delete();
            log_tx.delete();
            rd_log.delete();
            n_wr = 0;
            n_rd = 0;
            n_wrr = 0;
            wr_idx = 0;
         end
         if (!rst_n || iic_rst) begin
            m_dly = -1;
            iic_busy = 1'b0;
         end else if (m_dly > 0) begin
            m_dly--;
         end else if (m_dly == 0) begin
            iic_qvld = 1'b1;
            iic_busy = 1'b0;
            m_dly = -1;
         end
         if (rst_n && iic_event_start) begin
            log_sel.push_back(iic_sel);
            iic_busy = 1'b1;
            m_dly = 1;
            if (iic_sel == 8'h03) begin
               log_tx.push_back(iic_send_data);
               iic_ack = (n_wr != nack_idx);
               n_wr++;
            end
            if (iic_sel == 8'h04 || iic_sel == 8'h05) begin
               iic_rec_data = (n_rd < rd_q.size()) ? rd_q[n_rd] : 8'hEE;
               n_rd++;
               if (hang_rd) m_dly = -1;
            end
         end
         if (wr_ready) begin
            n_wrr++;
            wr_idx++;
         end
         if (rd_valid) rd_log.push_back(rd_data);
         if (done) n_done++;
         wr_valid = wr_en && (wr_idx < wr_q.size());
         wr_data = (wr_idx < wr_q.size()) ? wr_q[wr_idx] : 8'h00;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_seq(input string tag, input int which,
                          input int n, input logic [127:0] exp);
      int sz;
      logic [7:0] v;
      sz = (which == 0) ? log_sel.size() :
           (which == 1) ? log_tx.size() : rd_log.size();
      chk({tag, "_len"}, 16'(sz), 16'(n));
      if (sz == n) begin
         for (int i = 0; i < n; i++) begin
            v = (which == 0) ? log_sel[i] :
                (which == 1) ? log_tx[i] : rd_log[i];
            chk($sformatf("%s_%0d", tag, i), {8'h00, v},
                {8'h00, exp[(n-1-i)*8 +: 8]});
         end
      end
   endtask

   task automatic send_cmd(input logic rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [3:0] len);
      cmd_rw = rw;
      cmd_dev = dev;
      cmd_reg = rg;
      cmd_len = len;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("cmd_ready_low", {15'd0, cmd_ready}, 16'd0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      assert (done === 1'b1) else begin
         errors++;
         $error("FAIL %s: done observed %b expected 1", tag, done);
      end
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_ready"}, {15'd0, cmd_ready}, 16'd1);
   endtask

   task automatic new_test();
      clr_tok++;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      int k;
      int d0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
      chk("rst_iic_en", {15'd0, iic_en}, 16'd1);
      chk("rst_iic_rst", {15'd0, iic_rst}, 16'd0);
      chk("rst_iic_sel", {8'd0, iic_sel}, 16'h0000);
      chk("rst_send", {8'd0, iic_send_data}, 16'h0000);
      chk("rst_pulses",
          {12'd0, iic_event_start, wr_ready, rd_valid, done}, 16'd0);
      chk("rst_errs", {14'd0, err_nack, err_timeout}, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // write, len 2
      wr_q = '{8'hAA, 8'h55};
      new_test();
      send_cmd(1'b0, 7'h50, 8'h10, 4'd2);
      wait_done("wr", 300);
      chk_seq("wr_sel", 0, 6, {8'h01, 8'h03, 8'h03, 8'h03, 8'h03, 8'h02});
      chk_seq("wr_tx", 1, 4, {8'hA0, 8'h10, 8'hAA, 8'h55});
      chk("wr_ready_cnt", 16'(n_wrr), 16'd2);
      chk("wr_errs", {14'd0, err_nack, err_timeout}, 16'd0);

      // read, len 3
      rd_q = '{8'h11, 8'h22, 8'h33};
      new_test();
      send_cmd(1'b1, 7'h50, 8'h20, 4'd3);
      wait_done("rd", 400);
      chk_seq("rd_sel", 0, 9, {8'h01, 8'h03, 8'h03, 8'h01, 8'h03,
                               8'h04, 8'h04, 8'h05, 8'h02});
      chk_seq("rd_tx", 1, 3, {8'hA0, 8'h20, 8'hA1});
      chk_seq("rd_data", 2, 3, {8'h11, 8'h22, 8'h33});
      chk("rd_hold", {8'd0, rd_data}, 16'h0033);
      chk("rd_errs", {14'd0, err_nack, err_timeout}, 16'd0);

      // address NACK on a write
      wr_q = '{8'h99, 8'h98};
      nack_idx = 0;
      new_test();
      send_cmd(1'b0, 7'h50, 8'h10, 4'd2);
      wait_done("nack", 300);
      nack_idx = -1;
      chk_seq("nack_sel", 0, 3, {8'h01, 8'h03, 8'h02});
      chk("nack_err", {15'd0, err_nack}, 16'd1);
      chk("nack_to", {15'd0, err_timeout}, 16'd0);
      chk("nack_wrr", 16'(n_wrr), 16'd0);
      chk("nack_rd", 16'(rd_log.size()), 16'd0);

      // timeout on a read byte
      rd_q = '{8'h77};
      hang_rd = 1'b1;
      new_test();
      send_cmd(1'b1, 7'h50, 8'h44, 4'd1);
      chk("to_nack_clr", {15'd0, err_nack}, 16'd0);
      k = 0;
      while (!(iic_event_start === 1'b1 && iic_sel === 8'h05) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("to_launch", {15'd0, iic_event_start}, 16'd1);
      repeat (99) @(negedge clk);
      chk("to_early", {15'd0, err_timeout}, 16'd0);
      @(negedge clk);
      chk("to_err", {15'd0, err_timeout}, 16'd1);
      chk("to_rst_a", {15'd0, iic_rst}, 16'd1);
      repeat (3) @(negedge clk);
      chk("to_rst_b", {15'd0, iic_rst}, 16'd1);
      @(negedge clk);
      chk("to_rst_end", {15'd0, iic_rst}, 16'd0);
      chk("to_done", {15'd0, done}, 16'd1);
      @(negedge clk);
      chk("to_ready", {15'd0, cmd_ready}, 16'd1);
      chk("to_sticky", {15'd0, err_timeout}, 16'd1);
      hang_rd = 1'b0;
      @(negedge clk);
      chk_seq("to_sel", 0, 6, {8'h01, 8'h03, 8'h03, 8'h01, 8'h03, 8'h05});

      // len 0 write with a long wr_valid stall
      wr_q = '{8'h5C, 8'h77};
      wr_en = 1'b0;
      new_test();
      d0 = n_done;
      send_cmd(1'b0, 7'h2A, 8'h33, 4'd0);
      repeat (160) @(negedge clk);
      chk("stall_events", 16'(log_sel.size()), 16'd3);
      chk("stall_to", {15'd0, err_timeout}, 16'd0);
      chk("stall_nodone", 16'(n_done - d0), 16'd0);
      wr_en = 1'b1;
      wait_done("len0", 300);
      chk_seq("len0_sel", 0, 5, {8'h01, 8'h03, 8'h03, 8'h03, 8'h02});
      chk_seq("len0_tx", 1, 3, {8'h54, 8'h33, 8'h5C});
      chk("len0_wrr", 16'(n_wrr), 16'd1);

      // reset in the middle of a read
      rd_q = '{8'h11, 8'h22, 8'h33};
      new_test();
      d0 = n_done;
      send_cmd(1'b1, 7'h50, 8'h20, 4'd3);
      k = 0;
      while (rd_valid !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("mid_rdv", {15'd0, rd_valid}, 16'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_ready", {15'd0, cmd_ready}, 16'd1);
      chk("mid_sel", {8'd0, iic_sel}, 16'h0000);
      chk("mid_rd", {8'd0, rd_data}, 16'h0000);
      chk("mid_out",
          {10'd0, iic_en, iic_rst, iic_event_start, wr_ready, rd_valid, done},
          16'h0020);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_nodone", 16'(n_done - d0), 16'd0);
      chk("mid_idle", {15'd0, cmd_ready}, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
